// File: rtl/alu_pkg.sv
// ALU opcode encoding and default datapath width shared by alu_unit and alu_muldiv.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_MUL = 4'b0101,
    ALU_DIV = 4'b0110,
    ALU_OR  = 4'b0111,
    ALU_AND = 4'b1000,
    ALU_XOR = 4'b1001,
    ALU_SLL = 4'b1010,
    ALU_SRL = 4'b1011,
    ALU_SLT = 4'b1100
  } alu_op_e;

endpackage

// File: rtl/alu_muldiv.sv
// Unsigned multiply/divide unit with the MIPS-style Hi/Lo/remain registers.
// Divide by zero yields quotient all-ones and remainder = rda, without trapping.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdx,
  input  logic [3:0]       alu_decode,
  output logic [WIDTH-1:0] mul_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] remain
);

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   rem;

  // Full-width product plus quotient/remainder, with the divide-by-zero substitution.
  always_comb begin
    product = {{WIDTH{1'b0}}, rda} * {{WIDTH{1'b0}}, rdx};
    if (rdx == '0) begin
      quot = '1;
      rem  = rda;
    end else begin
      quot = rda / rdx;
      rem  = rda % rdx;
    end
  end

  assign mul_lo = product[WIDTH-1:0];

  // Capture MUL/DIV results; every other opcode leaves the registers alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hi     <= '0;
      Lo     <= '0;
      remain <= '0;
    end else if (alu_decode == ALU_MUL) begin
      Hi <= product[2*WIDTH-1:WIDTH];
      Lo <= product[WIDTH-1:0];
    end else if (alu_decode == ALU_DIV) begin
      Hi     <= rem;
      Lo     <= quot;
      remain <= rem;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// 32-bit integer ALU: combinational result/zero, registered Hi/Lo/remain.
// Optional signed-overflow output enabled by defining ALU_OVF_EN.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rda,
  input  logic [WIDTH-1:0] rdx,
  input  logic [3:0]       alu_decode,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] remain
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] quot;
  logic [SHW-1:0]   shamt;
  logic             slt;

  assign sum   = rda + rdx;
  assign diff  = rda - rdx;
  assign shamt = rdx[SHW-1:0];
  assign slt   = $signed(rda) < $signed(rdx);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst        (rst),
    .rda        (rda),
    .rdx        (rdx),
    .alu_decode (alu_decode),
    .mul_lo     (mul_lo),
    .quot       (quot),
    .Hi         (Hi),
    .Lo         (Lo),
    .remain     (remain)
  );

  // Result select; unassigned opcodes drive zero.
  always_comb begin
    result = '0;
    case (alu_decode)
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_MUL: result = mul_lo;
      ALU_DIV: result = quot;
      ALU_OR:  result = rda | rdx;
      ALU_AND: result = rda & rdx;
      ALU_XOR: result = rda ^ rdx;
      ALU_SLL: result = rda << shamt;
      ALU_SRL: result = rda >> shamt;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVF_EN
  // Two's-complement overflow, only meaningful for ADD and SUB.
  always_comb begin
    ovf = 1'b0;
    if (alu_decode == ALU_ADD)
      ovf = (rda[WIDTH-1] == rdx[WIDTH-1]) && (sum[WIDTH-1] != rda[WIDTH-1]);
    else if (alu_decode == ALU_SUB)
      ovf = (rda[WIDTH-1] != rdx[WIDTH-1]) && (diff[WIDTH-1] != rda[WIDTH-1]);
  end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed plan steps plus random ops vs a reference model.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rda, rdx;
  logic [3:0]  alu_decode;
  logic [31:0] result, Hi, Lo, remain;
  logic        zero;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference copies of the architectural registers.
  logic [31:0] m_hi, m_lo, m_rem;

  always #5 clk = ~clk;

  alu_unit dut (
    .clk        (clk),
    .rst        (rst),
    .rda        (rda),
    .rdx        (rdx),
    .alu_decode (alu_decode),
    .result     (result),
    .zero       (zero),
    .Hi         (Hi),
    .Lo         (Lo),
    .remain     (remain)
`ifdef ALU_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result computed from the arithmetic meaning of each opcode.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned wa = a;
    longint unsigned wb = b;
    int sa = a;
    int sb = b;
    case (op)
      4'd1:    return 32'(wa + wb);
      4'd2:    return 32'(wa - wb);
      4'd5:    return 32'(wa * wb);
      4'd6:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd7:    return a | b;
      4'd8:    return a & b;
      4'd9:    return a ^ b;
      4'd10:   return 32'(wa << (b % 32));
      4'd11:   return 32'(wa >> (b % 32));
      4'd12:   return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(int'(a));
    longint sb = longint'(int'(b));
    longint r;
    if (op == 4'd1)      r = sa + sb;
    else if (op == 4'd2) r = sa - sb;
    else                 return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // One operation: check combinational outputs, clock it, check registers.
  task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    longint unsigned p;
    @(negedge clk);
    alu_decode = op; rda = a; rdx = b;
    #1;
    er = ref_result(op, a, b);
    check({tag, " result"}, result, er);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
`ifdef ALU_OVF_EN
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, ref_ovf(op, a, b)});
`endif
    @(posedge clk);
    if (op == 4'd5) begin
      p = longint'(a) * longint'(b);
      m_hi = p[63:32]; m_lo = p[31:0];
    end else if (op == 4'd6) begin
      m_lo  = (b == 0) ? 32'hFFFF_FFFF : a / b;
      m_hi  = (b == 0) ? a : a % b;
      m_rem = m_hi;
    end
    #1;
    check({tag, " Hi"}, Hi, m_hi);
    check({tag, " Lo"}, Lo, m_lo);
    check({tag, " remain"}, remain, m_rem);
  endtask

  initial begin
    rst = 1'b1; rda = 32'd0; rdx = 32'd0; alu_decode = 4'd0;
    m_hi = 32'd0; m_lo = 32'd0; m_rem = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset Hi", Hi, 32'd0);
    check("reset Lo", Lo, 32'd0);
    check("reset remain", remain, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    apply("ADD 5,3", 4'b0001, 32'd5, 32'd3);
    check("ADD 5,3 const", result, 32'd8);
    apply("SUB 5,3", 4'b0010, 32'd5, 32'd3);
    check("SUB 5,3 const", result, 32'd2);
    apply("SUB 3,3", 4'b0010, 32'd3, 32'd3);
    check("SUB 3,3 zero", {31'd0, zero}, 32'd1);
    apply("MUL 5,3", 4'b0101, 32'd5, 32'd3);
    check("MUL 5,3 Lo const", Lo, 32'd15);
    check("MUL 5,3 Hi const", Hi, 32'd0);
    apply("MUL ff,2", 4'b0101, 32'hFFFF_FFFF, 32'd2);
    check("MUL ff,2 Lo const", Lo, 32'hFFFF_FFFE);
    check("MUL ff,2 Hi const", Hi, 32'd1);
    apply("DIV 10,2", 4'b0110, 32'd10, 32'd2);
    check("DIV 10,2 Lo const", Lo, 32'd5);
    check("DIV 10,2 rem const", remain, 32'd0);
    apply("DIV 7,0", 4'b0110, 32'd7, 32'd0);
    check("DIV 7,0 rem const", remain, 32'd7);
    check("DIV 7,0 Lo const", Lo, 32'hFFFF_FFFF);
    apply("OR", 4'b0111, 32'h55, 32'hAA);
    apply("AND", 4'b1000, 32'h55, 32'hAA);
    apply("XOR", 4'b1001, 32'h55, 32'hAA);
    apply("op1101", 4'b1101, 32'h55, 32'hAA);
    check("op1101 Lo held", Lo, 32'hFFFF_FFFF);
    apply("SLL 8000_0000,16", 4'b1010, 32'h8000_0000, 32'd16);
    apply("SRL f0f0f0,5", 4'b1011, 32'h00F0_F0F0, 32'd5);
    check("SRL const", result, 32'h0007_8787);
    apply("SRL 12345678,1", 4'b1011, 32'h1234_5678, 32'd1);
    check("SRL1 const", result, 32'h091A_2B3C);
    apply("SRL by 33", 4'b1011, 32'h1234_5678, 32'd33);
    check("SRL33 const", result, 32'h091A_2B3C);
    apply("SLL by 0", 4'b1010, 32'hDEAD_BEEF, 32'd0);
    apply("SLT 10,1", 4'b1100, 32'h10, 32'd1);
    apply("SLT -1,1", 4'b1100, 32'hFFFF_FFFF, 32'd1);
    check("SLT -1,1 const", result, 32'd1);
    apply("ADD ovf", 4'b0001, 32'h7FFF_FFFF, 32'd1);
    apply("SUB ovf", 4'b0010, 32'h8000_0000, 32'd1);

    // Asynchronous reset between edges after a MUL.
    apply("MUL pre-rst", 4'b0101, 32'h1234_5678, 32'h9ABC_DEF0);
    #2;
    rst = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0; m_rem = 32'd0;
    #1;
    check("async rst Hi", Hi, 32'd0);
    check("async rst Lo", Lo, 32'd0);
    check("async rst remain", remain, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply("MUL post-rst", 4'b0101, 32'd7, 32'd6);

    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      apply($sformatf("rand%0d op%0d", i, op), op, a, b);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU for the single-cycle/multicycle CPU datapath.
- Computes a combinational result and zero flag from two register operands and a 4-bit decode.
- Holds MIPS-style HI/LO/remainder registers, written on the clock edge by MUL and DIV.

Parameters:
WIDTH, 32, operand/result width; shift amount uses low $clog2(WIDTH) bits of rdx.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
rda  input  WIDTH  operand A
rdx  input  WIDTH  operand B / shift amount
alu_decode  input  4  operation select
result  output  WIDTH  combinational result
zero  output  1  combinational, 1 when result == 0
Hi  output  WIDTH  registered upper product / remainder
Lo  output  WIDTH  registered lower product / quotient
remain  output  WIDTH  registered remainder of last DIV

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1, Hi, Lo and remain = 0. result and zero stay combinational and are unaffected by reset.
- Opcodes; result is combinational with 0 cycle latency:
  - 0001 ADD: rda+rdx, modulo 2^WIDTH.
  - 0010 SUB: rda-rdx, modulo 2^WIDTH.
  - 0101 MUL: unsigned 2*WIDTH product; result = low WIDTH bits.
  - 0110 DIV: unsigned; result = quotient.
  - 0111 OR.
  - 1000 AND.
  - 1001 XOR.
  - 1010 SLL: rda << rdx[4:0].
  - 1011 SRL: logical shift, rda >> rdx[4:0], zero-fill.
  - 1100 SLT: signed compare; result = 1 if rda < rdx, else 0.
  - 0000, 0011, 0100, 1101-1111: result = 0. Registers hold.
- Shift amount: upper bits of rdx are ignored (rdx=33 shifts by 1). A shift amount of 0 passes rda through unchanged.
- Divide by zero (rdx=0): quotient = all ones, remainder = rda. No trap.
- Register update, on rising clk when rst=0:
  - MUL: Hi <= product[63:32], Lo <= product[31:0]; remain holds.
  - DIV: Lo <= quotient, Hi <= remainder, remain <= remainder.
  - Any other opcode: Hi, Lo and remain hold.
- Latency: Hi/Lo/remain are valid one cycle after the edge that samples the MUL/DIV.
- Reset asserted mid-operation clears the registers immediately. The first edge after release samples normally.

Optional Feature:
- Macro: ALU_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, combinational).
  - ovf = signed two's-complement overflow for ADD (operands same sign, result sign differs) and for SUB (operands differ in sign, result sign differs from rda).
  - ovf = 0 for all other opcodes.
- When undefined: port absent, no overflow logic.

Decomposition:
- alu_pkg holds:
  - a typedef enum logic [3:0] of the opcodes (ALU_ADD ... ALU_SLT);
  - the WIDTH default constant.
- Natural sub-module: alu_muldiv, containing the combinational product/quotient/remainder (including the divide-by-zero rule) plus the Hi/Lo/remain registers.
- The top level holds the result mux and zero detect.

Test Plan:
- ADD rda=5, rdx=3 -> result=8, zero=0. SUB 5,3 -> result=2. SUB 3,3 -> result=0, zero=1.
- MUL rda=5, rdx=3, one clk edge -> Lo=15, Hi=0. MUL 0xFFFFFFFF, 2 -> Lo=0xFFFFFFFE, Hi=1.
- DIV rda=10, rdx=2 -> result=5; after edge Lo=5, remain=0. DIV 7,0 -> result=0xFFFFFFFF; after edge remain=7.
- Logic ops, rda=0x55, rdx=0xAA: OR=0xFF, AND=0, XOR=0xFF. Then switch to opcode 1101 -> result=0, zero=1, Hi/Lo unchanged.
- Shifts:
  - SLL 0x80000000 by 16 -> 0.
  - SRL 0x00F0F0F0 by 5 -> 0x00078787.
  - SRL 0x12345678 by 1 -> 0x091A2B3C.
- SLT 0x10 vs 1 -> 0. SLT 0xFFFFFFFF vs 1 -> 1.
- Reset: assert rst asynchronously after a MUL -> Hi/Lo/remain = 0 immediately, before any clock edge.
- With ALU_OVF_EN: ADD 0x7FFFFFFF+1 -> ovf=1.
